// File: rtl/rf_multi.sv
// rf_multi: multi-read-port register file with byte-enabled writes,
// same-cycle write forwarding, a per-entry pending scoreboard and a
// sequential clear sweep that also runs after reset.

// One read port: combinational lookup with optional write forwarding.
module rf_multi_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]   ra,
    input  logic [DATA_W-1:0]   stored,
    input  logic                pend_bit,
    input  logic                busy,
    input  logic                wr_acc,
    input  logic [ADDR_W-1:0]   wa,
    input  logic [DATA_W-1:0]   wd,
    input  logic [DATA_W/8-1:0] wbe,
    output logic [DATA_W-1:0]   rd,
    output logic                rd_pend
);
    logic              is_zero;
    logic              hit;
    logic [DATA_W-1:0] merged;

    // Resolve read data and pending flag, forwarding an in-flight write.
    always_comb begin
        is_zero = (ZERO_REG != 0) && (ra == '0);
        hit     = (BYPASS != 0) && wr_acc && (wa == ra) && !is_zero;
        merged  = stored;
        for (int b = 0; b < DATA_W/8; b++) begin
            if (wbe[b]) merged[b*8 +: 8] = wd[b*8 +: 8];
        end
        rd      = '0;
        rd_pend = 1'b0;
        if (!busy && !is_zero) begin
            rd      = hit ? merged : stored;
            rd_pend = hit ? 1'b0 : pend_bit;
        end
    end
endmodule

module rf_multi #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       we,
    input  logic [DATA_W/8-1:0]        wbe,
    input  logic [ADDR_W-1:0]          wa,
    input  logic [DATA_W-1:0]          wd,
    output logic                       wr_rdy,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic [NUM_RD-1:0]          rd_pend,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_addr,
    input  logic                       clr_req,
    output logic                       clr_busy,
    output logic                       pend_any
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic              wr_acc;
    logic              iss_acc;
    logic              wa_zero;
    logic              iss_zero;

    // Holding reset low counts as busy so nothing leaks out before the sweep.
    assign clr_busy = (state == CLEAR) || !reset;
    assign wr_rdy   = !clr_busy;
    assign wr_acc   = we && wr_rdy;
    assign iss_acc  = iss_valid && wr_rdy;
    assign wa_zero  = (ZERO_REG != 0) && (wa == '0);
    assign iss_zero = (ZERO_REG != 0) && (iss_addr == '0);
    assign pend_any = |pend;

    // Clear FSM: reset or clr_req starts a DEPTH-cycle sweep from entry 0.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= CLEAR;
            cptr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        cptr  <= '0;
                    end
                end
                CLEAR: begin
                    cptr <= cptr + 1'b1;
                    if (cptr == '1) state <= IDLE;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Storage: sweep zeroes one entry per cycle, otherwise byte-merged writes.
    always_ff @(posedge clock) begin
        if (state == CLEAR) begin
            mem[cptr] <= '0;
        end else if (wr_acc && !wa_zero) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wbe[b]) mem[wa][b*8 +: 8] <= wd[b*8 +: 8];
            end
        end
    end

    // Pending scoreboard: write clears, issue sets (set applied last so it wins).
    always_ff @(posedge clock) begin
        if (!reset) begin
            pend <= '0;
        end else if (state == IDLE && clr_req) begin
            pend <= '0;
        end else begin
            if (wr_acc)              pend[wa]       <= 1'b0;
            if (iss_acc && !iss_zero) pend[iss_addr] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_k;
        assign ra_k = ra[k*ADDR_W +: ADDR_W];

        rf_multi_rdport #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rd (
            .ra      (ra_k),
            .stored  (mem[ra_k]),
            .pend_bit(pend[ra_k]),
            .busy    (clr_busy),
            .wr_acc  (wr_acc),
            .wa      (wa),
            .wd      (wd),
            .wbe     (wbe),
            .rd      (rd[k*DATA_W +: DATA_W]),
            .rd_pend (rd_pend[k])
        );
    end
endmodule

// File: tb/tb_rf_multi.sv
// Directed self-checking bench for rf_multi at default parameters.
module tb_rf_multi;
    logic        clock = 1'b0;
    logic        reset;
    logic        we;
    logic [3:0]  wbe;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        wr_rdy;
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rd_pend;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        clr_req;
    logic        clr_busy;
    logic        pend_any;

    int n_cmp  = 0;
    int n_fail = 0;

    rf_multi dut (
        .clock(clock), .reset(reset), .we(we), .wbe(wbe), .wa(wa), .wd(wd),
        .wr_rdy(wr_rdy), .ra(ra), .rd(rd), .rd_pend(rd_pend),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .clr_req(clr_req),
        .clr_busy(clr_busy), .pend_any(pend_any)
    );

    always #5 clock = ~clock;

    // Advance one edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        we = 0; wbe = 4'h0; wa = 0; wd = 0;
        iss_valid = 0; iss_addr = 0; clr_req = 0;
    endtask

    task automatic test_reset();
        int n;
        reset = 0; idle_inputs(); ra = {5'd31, 5'd5};
        tick(); tick(); tick();
        #1;
        n_cmp++; if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", clr_busy); end
        n_cmp++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_wr_rdy: got %b want 0", wr_rdy); end
        n_cmp++; if (rd !== 64'h0) begin n_fail++; $display("FAIL rst_rd: got %h want 0", rd); end
        n_cmp++; if (pend_any !== 1'b0 || rd_pend !== 2'b00) begin n_fail++; $display("FAIL rst_pend: got %b/%b want 0/00", pend_any, rd_pend); end
        reset = 1;
        n = 0;
        while (clr_busy === 1'b1 && n < 100) begin tick(); n++; end
        n_cmp++; if (n !== 32) begin n_fail++; $display("FAIL rst_sweep_len: got %0d want 32", n); end
        n_cmp++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_wr_rdy: got %b want 1", wr_rdy); end
        n_cmp++; if (rd !== 64'h0) begin n_fail++; $display("FAIL post_rst_rd: got %h want 0", rd); end
    endtask

    task automatic test_byte_write();
        ra = {5'd3, 5'd3};
        we = 1; wa = 3; wd = 32'hAABBCCDD; wbe = 4'b1111;
        #1;
        n_cmp++; if (rd[31:0] !== 32'hAABBCCDD) begin n_fail++; $display("FAIL bypass_full: got %h want aabbccdd", rd[31:0]); end
        tick();
        wd = 32'h11223344; wbe = 4'b0101;
        #1;
        n_cmp++; if (rd[31:0] !== 32'hAA22CC44) begin n_fail++; $display("FAIL bypass_merge0: got %h want aa22cc44", rd[31:0]); end
        n_cmp++; if (rd[63:32] !== 32'hAA22CC44) begin n_fail++; $display("FAIL bypass_merge1: got %h want aa22cc44", rd[63:32]); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (rd[31:0] !== 32'hAA22CC44) begin n_fail++; $display("FAIL stored_merge: got %h want aa22cc44", rd[31:0]); end
    endtask

    task automatic test_zero_reg();
        ra = {5'd0, 5'd0};
        we = 1; wa = 0; wd = 32'hFFFFFFFF; wbe = 4'hF;
        #1;
        n_cmp++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL zero_wr_rdy: got %b want 1", wr_rdy); end
        n_cmp++; if (rd !== 64'h0) begin n_fail++; $display("FAIL zero_same: got %h want 0", rd); end
        tick();
        idle_inputs();
        iss_valid = 1; iss_addr = 0;
        #1;
        n_cmp++; if (rd !== 64'h0) begin n_fail++; $display("FAIL zero_next: got %h want 0", rd); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (rd_pend !== 2'b00 || pend_any !== 1'b0) begin n_fail++; $display("FAIL zero_pend: got %b/%b want 00/0", rd_pend, pend_any); end
    endtask

    task automatic test_pending();
        ra = {5'd8, 5'd7};
        iss_valid = 1; iss_addr = 7;
        #1;
        n_cmp++; if (rd_pend !== 2'b00) begin n_fail++; $display("FAIL pend_before: got %b want 00", rd_pend); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (rd_pend !== 2'b01 || pend_any !== 1'b1) begin n_fail++; $display("FAIL pend_set: got %b/%b want 01/1", rd_pend, pend_any); end
        iss_valid = 1; iss_addr = 7; we = 1; wa = 7; wd = 32'h12345678; wbe = 4'hF;
        #1;
        n_cmp++; if (rd_pend[0] !== 1'b0 || rd[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL pend_bypass: got %b/%h want 0/12345678", rd_pend[0], rd[31:0]); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (rd_pend !== 2'b01 || pend_any !== 1'b1) begin n_fail++; $display("FAIL pend_set_wins: got %b/%b want 01/1", rd_pend, pend_any); end
        we = 1; wa = 7; wd = 32'h0; wbe = 4'h0;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (rd_pend !== 2'b00 || pend_any !== 1'b0) begin n_fail++; $display("FAIL pend_cleared: got %b/%b want 00/0", rd_pend, pend_any); end
        n_cmp++; if (rd[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL wbe0_keep: got %h want 12345678", rd[31:0]); end
    endtask

    task automatic test_back_to_back();
        ra = {5'd13, 5'd12};
        we = 1; wa = 12; wd = 32'hCAFE0012; wbe = 4'hF;
        tick();
        wa = 13; wd = 32'hBEEF0013;
        #1;
        n_cmp++; if (rd !== {32'hBEEF0013, 32'hCAFE0012}) begin n_fail++; $display("FAIL b2b_ports: got %h want beef0013cafe0012", rd); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (rd !== {32'hBEEF0013, 32'hCAFE0012}) begin n_fail++; $display("FAIL b2b_stored: got %h want beef0013cafe0012", rd); end
    endtask

    task automatic test_clear();
        int n;
        for (int i = 1; i <= 4; i++) begin
            we = 1; wa = 5'(i); wd = 32'h10000000 + i; wbe = 4'hF;
            tick();
        end
        idle_inputs();
        iss_valid = 1; iss_addr = 10;
        tick();
        idle_inputs();
        ra = {5'd10, 5'd2};
        #1;
        n_cmp++; if (rd[31:0] !== 32'h10000002 || pend_any !== 1'b1) begin n_fail++; $display("FAIL pre_clear: got %h/%b want 10000002/1", rd[31:0], pend_any); end
        clr_req = 1; we = 1; wa = 5; wd = 32'h55; wbe = 4'hF;
        #1;
        n_cmp++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL clr_req_wr_rdy: got %b want 1", wr_rdy); end
        tick();
        clr_req = 0; wa = 6; wd = 32'h66; iss_valid = 1; iss_addr = 9;
        ra = {5'd5, 5'd1};
        #1;
        n_cmp++; if (clr_busy !== 1'b1 || wr_rdy !== 1'b0) begin n_fail++; $display("FAIL clr_start: got %b/%b want 1/0", clr_busy, wr_rdy); end
        n_cmp++; if (rd !== 64'h0 || rd_pend !== 2'b00 || pend_any !== 1'b0) begin n_fail++; $display("FAIL clr_outputs: got %h/%b/%b want 0/00/0", rd, rd_pend, pend_any); end
        n = 0;
        while (clr_busy === 1'b1 && n < 100) begin
            clr_req = (n == 5);
            tick();
            n++;
        end
        idle_inputs();
        n_cmp++; if (n !== 32) begin n_fail++; $display("FAIL clr_sweep_len: got %0d want 32", n); end
        #1;
        n_cmp++; if (rd !== 64'h0) begin n_fail++; $display("FAIL clr_entries_1_5: got %h want 0", rd); end
        ra = {5'd6, 5'd9};
        #1;
        n_cmp++; if (rd !== 64'h0 || rd_pend !== 2'b00 || pend_any !== 1'b0) begin n_fail++; $display("FAIL clr_dropped: got %h/%b/%b want 0/00/0", rd, rd_pend, pend_any); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        we = 1; wa = 20; wd = 32'h20; wbe = 4'hF;
        tick();
        idle_inputs();
        clr_req = 1;
        tick();
        clr_req = 0;
        repeat (10) tick();
        reset = 0;
        tick();
        #1;
        n_cmp++; if (clr_busy !== 1'b1 || wr_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b/%b want 1/0", clr_busy, wr_rdy); end
        reset = 1;
        n = 0;
        while (clr_busy === 1'b1 && n < 100) begin tick(); n++; end
        n_cmp++; if (n !== 32) begin n_fail++; $display("FAIL mid_rst_sweep_len: got %0d want 32", n); end
        ra = {5'd20, 5'd20};
        #1;
        n_cmp++; if (rd !== 64'h0 || wr_rdy !== 1'b1) begin n_fail++; $display("FAIL mid_rst_after: got %h/%b want 0/1", rd, wr_rdy); end
    endtask

    initial begin
        test_reset();
        test_byte_write();
        test_zero_reg();
        test_pending();
        test_back_to_back();
        test_clear();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_multi.md
RF_MULTI -- requirements
Module: rf_multi

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, entry 0 is hardwired to zero and never pending.
REQ-005 Parameter BYPASS, default 1, same-cycle write-to-read forwarding enabled.
REQ-006 clock  in  1  single clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 we  in  1  write request.
REQ-009 wbe  in  DATA_W/8  byte enables for the write (bit i covers byte i).
REQ-010 wa  in  ADDR_W  write address.
REQ-011 wd  in  DATA_W  write data.
REQ-012 wr_rdy  out  1  write/issue accepted this cycle; equals !clr_busy.
REQ-013 ra  in  NUM_RD*ADDR_W  read addresses; port k uses slice [k*ADDR_W +: ADDR_W].
REQ-014 rd  out  NUM_RD*DATA_W  read data; port k uses slice [k*DATA_W +: DATA_W].
REQ-015 rd_pend  out  NUM_RD  per-port pending flag for the addressed entry.
REQ-016 iss_valid  in  1  issue: mark iss_addr as pending (awaiting write).
REQ-017 iss_addr  in  ADDR_W  entry to mark pending.
REQ-018 clr_req  in  1  request a full clear sweep.
REQ-019 clr_busy  out  1  clear sweep in progress.
REQ-020 pend_any  out  1  OR of all pending bits.

Function
REQ-021 Reads SHALL be combinational: rd[k] = entry[ra[k]], zero-latency.
REQ-022 With ZERO_REG=1, a read of address 0 SHALL return 0 regardless of writes or bypass.
REQ-023 Accepted write = we && wr_rdy; at the clock edge each byte i with wbe[i]=1 SHALL be written, other bytes SHALL keep their value.
REQ-024 With ZERO_REG=1, writes to address 0 SHALL be discarded (still counted as accepted).
REQ-025 With BYPASS=1, if an accepted write targets ra[k] (non-zero when ZERO_REG=1), rd[k] SHALL show stored data merged with wd under wbe in the same cycle; with BYPASS=0, rd[k] SHALL show old contents until the next cycle.
REQ-026 Clear FSM states: IDLE, CLEAR; counter cptr of ADDR_W bits.
REQ-027 IDLE -> CLEAR when clr_req=1; cptr SHALL load 0 on entry.
REQ-028 In CLEAR, entry[cptr] SHALL be zeroed each cycle and cptr incremented; after clearing entry DEPTH-1, next state SHALL be IDLE (sweep occupies exactly DEPTH cycles).
REQ-029 clr_busy SHALL be 1 exactly while state=CLEAR; clr_req during CLEAR SHALL be ignored (no restart).
REQ-030 While clr_busy=1, rd SHALL read all zeros, rd_pend SHALL be 0, and we/iss_valid SHALL be dropped.
REQ-031 All pending bits SHALL be cleared on the cycle the FSM enters CLEAR.
REQ-032 Accepted iss_valid SHALL set pend[iss_addr] at the edge; accepted write SHALL clear pend[wa] at the edge.
REQ-033 Issue and write to the same address in one cycle: set SHALL win (pend=1 afterwards).
REQ-034 rd_pend[k] = pend[ra[k]], except 0 when BYPASS=1 and an accepted write targets ra[k] that cycle; with ZERO_REG=1 address 0 SHALL never be pending.
REQ-035 pend_any SHALL reflect registered pend bits only (no bypass).

Reset
REQ-036 reset=0 at a rising edge SHALL force state=CLEAR, cptr=0, all pend bits 0; storage is zeroed by the subsequent sweep, not by reset itself.
REQ-037 While reset=0 and the DEPTH cycles after release: clr_busy=1, wr_rdy=0, rd=0, rd_pend=0, pend_any=0.
REQ-038 reset asserted mid-sweep SHALL restart the sweep from cptr=0.

Verification
REQ-039 Release reset, count cycles -> clr_busy high for exactly 32 cycles (defaults), then wr_rdy=1 and all reads 0.
REQ-040 Write wa=3 wd=0xAABBCCDD wbe=4'b1111, then wa=3 wd=0x11223344 wbe=4'b0101 with ra[0]=3 -> same cycle rd[0]=0xAA22CC44, next cycle stored 0xAA22CC44.
REQ-041 Write wa=0 wd=0xFFFFFFFF, read ra=0 both ports -> 0 in same and following cycles.
REQ-042 Issue addr 7; next cycle rd_pend for ra=7 is 1, pend_any=1; issue 7 and write 7 same cycle -> stays pending; write 7 alone -> pending 0, pend_any=0.
REQ-043 Fill entries, assert clr_req with we=1 same cycle -> write accepted, sweep starts next cycle, we dropped for 32 cycles, all entries 0 afterwards.
REQ-044 Assert reset for one cycle at sweep cycle 10 -> clr_busy persists 32 further cycles after release.
